layer_compositor: RTL and testbench

Per-pixel layer sequencer for the ARGB4444 compositing path. It accepts one background pixel plus a layer-enable mask. For each enabled layer, bottom to top, it fetches the layer's pixel and time-shares the single 1-cycle-latency blend unit. It accumulates the composited result and presents the finished pixel on a valid/ready output. It sits between the pixel scheduler and the scan-out FIFO and owns no arithmetic of its own.

---
 rtl/compositor_pkg.sv | 29 ++
 rtl/layer_compositor_if.sv | 48 ++++
 rtl/layer_pick.sv | 25 ++
 rtl/layer_compositor.sv | 134 +++++++++++++
 tb/tb_layer_compositor.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/compositor_pkg.sv
// Shared definitions for the ARGB4444 layer compositor: pixel nibble positions,
// sequencer states and the opaque alpha constant.
package compositor_pkg;

  localparam int R_LSB = 0;
  localparam int R_MSB = 3;
  localparam int G_LSB = 4;
  localparam int G_MSB = 7;
  localparam int B_LSB = 8;
  localparam int B_MSB = 11;
  localparam int A_LSB = 12;
  localparam int A_MSB = 15;

  localparam logic [3:0] ALPHA_OPAQUE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    BLEND,
    CAPT,
    OUT
  } state_t;

  function automatic logic [3:0] alphaOf(input logic [15:0] pix);
    return pix[A_MSB:A_LSB];
  endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Bundle of the compositor's job, fetch, blend and output buses.
// The slave modport is the compositor's view; master is the surrounding system.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
);

  logic                  pix_valid;
  logic                  pix_ready;
  logic [15:0]           pix_bg;
  logic [NUM_LAYERS-1:0] pix_layer_en;

  logic                  fetch_req;
  logic [LAYER_W-1:0]    fetch_layer;
  logic                  fetch_valid;
  logic [15:0]           fetch_data;

  logic [15:0]           blend_prev;
  logic [15:0]           blend_add;
  logic [15:0]           blend_out;

  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_pixel;

  logic                  busy;

  modport master (
    output pix_valid, pix_bg, pix_layer_en,
    output fetch_valid, fetch_data,
    output blend_out,
    output out_ready,
    input  pix_ready, fetch_req, fetch_layer,
    input  blend_prev, blend_add,
    input  out_valid, out_pixel, busy
  );

  modport slave (
    input  pix_valid, pix_bg, pix_layer_en,
    input  fetch_valid, fetch_data,
    input  blend_out,
    input  out_ready,
    output pix_ready, fetch_req, fetch_layer,
    output blend_prev, blend_add,
    output out_valid, out_pixel, busy
  );

endinterface

// File: rtl/layer_pick.sv
// Combinational lowest-set-bit finder: returns the one-hot of the lowest
// enabled layer and its index, so layers are visited bottom to top.
module layer_pick #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
) (
  input  logic [NUM_LAYERS-1:0] mask,
  output logic [NUM_LAYERS-1:0] oneHot,
  output logic [LAYER_W-1:0]    index
);

  // Scanning downwards lets the lowest set bit win the last assignment.
  always_comb begin
    oneHot = '0;
    index  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        oneHot    = '0;
        oneHot[i] = 1'b1;
        index     = LAYER_W'(i);
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Per-pixel layer sequencer: walks the enabled layers bottom to top, fetches
// each one and time-shares the external 1-cycle blend unit to build the pixel.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  layer_compositor_if.slave bus
);

  state_t                state;
  state_t                nextState;
  logic [15:0]           acc;
  logic [15:0]           lay;
  logic [15:0]           blendPrevQ;
  logic [15:0]           blendAddQ;
  logic [NUM_LAYERS-1:0] mask;
  logic [NUM_LAYERS-1:0] pickOneHot;
  logic [LAYER_W-1:0]    pickIndex;
  logic                  fetchOpaque;

  layer_pick #(
    .NUM_LAYERS(NUM_LAYERS),
    .LAYER_W   (LAYER_W)
  ) picker (
    .mask  (mask),
    .oneHot(pickOneHot),
    .index (pickIndex)
  );

  assign fetchOpaque = (alphaOf(bus.fetch_data) != 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Fully transparent layers skip straight to the next fetch without a blend slot.
  always_comb begin
    nextState       = state;
    bus.pix_ready   = 1'b0;
    bus.fetch_req   = 1'b0;
    bus.fetch_layer = '0;
    bus.out_valid   = 1'b0;
    bus.busy        = 1'b1;
    bus.blend_prev  = blendPrevQ;
    bus.blend_add   = blendAddQ;
    bus.out_pixel   = {ALPHA_OPAQUE, acc[B_MSB:B_LSB], acc[G_MSB:G_LSB], acc[R_MSB:R_LSB]};
    case (state)
      IDLE: begin
        bus.pix_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.pix_valid) begin
          nextState = (bus.pix_layer_en == '0) ? OUT : REQ;
        end
      end
      REQ: begin
        bus.fetch_req   = 1'b1;
        bus.fetch_layer = pickIndex;
        nextState       = WAIT;
      end
      WAIT: begin
        if (bus.fetch_valid) begin
          if (fetchOpaque) begin
            nextState = BLEND;
          end else begin
            nextState = (mask != '0) ? REQ : OUT;
          end
        end
      end
      BLEND: begin
        bus.blend_prev = acc;
        bus.blend_add  = lay;
        nextState      = CAPT;
      end
      CAPT: begin
        nextState = (mask != '0) ? REQ : OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Blend operands are captured while driven so they hold once BLEND ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      lay        <= '0;
      mask       <= '0;
      blendPrevQ <= '0;
      blendAddQ  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pix_valid) begin
            acc  <= bus.pix_bg;
            mask <= bus.pix_layer_en;
          end
        end
        REQ: begin
          mask <= mask & ~pickOneHot;
        end
        WAIT: begin
          if (bus.fetch_valid) begin
            lay <= bus.fetch_data;
          end
        end
        BLEND: begin
          blendPrevQ <= acc;
          blendAddQ  <= lay;
        end
        CAPT: begin
          acc <= bus.blend_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with a fetch responder, a blend-unit
// model and a cycle-by-cycle compare against a per-job expected-result model.
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int NL = 4;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(NL), .LAYER_W(LW)) bus ();

  layer_compositor #(.NUM_LAYERS(NL), .LAYER_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  int acceptEdge = 0;
  int fetchLat = 1;
  logic [15:0] layerMem [NL];

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Blend unit: per channel prev + floor(alpha*(new-prev)/16), alpha kept from prev.
  function automatic logic [15:0] blendModel(input logic [15:0] prev, input logic [15:0] add);
    logic [15:0] res;
    int a, p, n, d;
    res = prev;
    a = int'(add[15:12]);
    for (int c = 0; c < 3; c++) begin
      p = int'(prev[4*c +: 4]);
      n = int'(add[4*c +: 4]);
      d = (a * (n - p)) >>> 4;
      res[4*c +: 4] = 4'((p + d) & 15);
    end
    return res;
  endfunction

  function automatic logic [15:0] expectPixel(input logic [15:0] bg, input logic [NL-1:0] m);
    logic [15:0] a;
    a = bg;
    for (int i = 0; i < NL; i++) begin
      if (m[i] && layerMem[i][15:12] != 4'h0) a = blendModel(a, layerMem[i]);
    end
    return {ALPHA_OPAQUE, a[11:0]};
  endfunction

  function automatic int expectLatency(input logic [NL-1:0] m);
    int lat;
    lat = 1;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) lat += 1 + fetchLat + ((layerMem[i][15:12] != 4'h0) ? 2 : 0);
    end
    return lat;
  endfunction

  always_ff @(posedge clk) begin
    edgeCount     <= edgeCount + 1;
    bus.blend_out <= blendModel(bus.blend_prev, bus.blend_add);
  end

  // Fetch responder: answers each request fetchLat cycles later, even across a reset.
  int pendCnt = 0;
  logic [LW-1:0] pendLayer = '0;
  initial begin
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.fetch_req === 1'b1) begin
        pendCnt   = fetchLat;
        pendLayer = bus.fetch_layer;
      end
      @(posedge clk);
      #1;
      bus.fetch_valid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          bus.fetch_valid = 1'b1;
          bus.fetch_data  = layerMem[pendLayer];
        end
      end
    end
  end

  bit jobActive = 1'b0;
  bit outSeen = 1'b0;
  int jobCnt = 0;
  int jobLat = 0;
  logic [15:0] jobPix = '0;
  int fetchQ [$];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      jobActive = 1'b0;
      outSeen   = 1'b0;
      fetchQ.delete();
    end else begin
      if (jobActive) jobCnt++;
      checkValue("busy", 32'(bus.busy), 32'(jobActive));
      checkValue("pix_ready", 32'(bus.pix_ready), 32'(!jobActive));
      if (bus.fetch_req === 1'b1) begin
        if (fetchQ.size() == 0) begin
          checkValue("fetch_unexpected", 32'(bus.fetch_req), 32'd0);
        end else begin
          checkValue("fetch_layer", 32'(bus.fetch_layer), 32'(fetchQ.pop_front()));
        end
      end
      if (!jobActive) begin
        checkValue("out_valid_idle", 32'(bus.out_valid), 32'd0);
      end else begin
        if (jobCnt == jobLat) checkValue("out_valid_latency", 32'(bus.out_valid), 32'd1);
        if (bus.out_valid === 1'b1) begin
          if (!outSeen) checkValue("out_first_cycle", 32'(jobCnt), 32'(jobLat));
          outSeen = 1'b1;
          checkValue("out_pixel_model", 32'(bus.out_pixel), 32'(jobPix));
          checkValue("fetch_quiet", 32'(bus.fetch_req), 32'd0);
          if (bus.out_ready === 1'b1) begin
            checkValue("fetch_drained", 32'(fetchQ.size()), 32'd0);
            jobActive = 1'b0;
          end
        end
      end
      if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
        jobActive = 1'b1;
        outSeen   = 1'b0;
        jobCnt    = 0;
        jobPix    = expectPixel(bus.pix_bg, bus.pix_layer_en);
        jobLat    = expectLatency(bus.pix_layer_en);
        for (int i = 0; i < NL; i++) begin
          if (bus.pix_layer_en[i]) fetchQ.push_back(i);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] bg, input logic [NL-1:0] m);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    bus.pix_bg       = bg;
    bus.pix_layer_en = m;
    bus.pix_valid    = 1'b1;
    @(negedge clk);
    while (bus.pix_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkValue("accept_ready", 32'(bus.pix_ready), 32'd1);
    acceptEdge = edgeCount;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expPix, input int expLat, input int hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkValue({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkValue({name, "_pixel"}, 32'(bus.out_pixel), 32'(expPix));
    checkValue({name, "_latency"}, 32'(edgeCount - acceptEdge), 32'(expLat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkValue({name, "_held_valid"}, 32'(bus.out_valid), 32'd1);
      checkValue({name, "_held_pixel"}, 32'(bus.out_pixel), 32'(expPix));
      checkValue({name, "_held_noready"}, 32'(bus.pix_ready), 32'd0);
      checkValue({name, "_held_nofetch"}, 32'(bus.fetch_req), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkValue({name, "_ready_after"}, 32'(bus.pix_ready), 32'd1);
    checkValue({name, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  bit sawStale;

  initial begin
    rst_n            = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_bg       = '0;
    bus.pix_layer_en = '0;
    bus.out_ready    = 1'b0;
    for (int i = 0; i < NL; i++) layerMem[i] = 16'hFFFF;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkValue("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
    checkValue("rst_busy", 32'(bus.busy), 32'd0);
    checkValue("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    checkValue("rst_fetch_layer", 32'(bus.fetch_layer), 32'd0);
    checkValue("rst_blend_prev", 32'(bus.blend_prev), 32'd0);
    checkValue("rst_blend_add", 32'(bus.blend_add), 32'd0);
    checkValue("rst_out_pixel", 32'(bus.out_pixel), 32'hF000);

    applyStimulus(16'h0123, 4'b0000);
    checkOutput("empty", 16'hF123, 1, 0);

    fetchLat = 3;
    layerMem[0] = 16'h8FFF;
    applyStimulus(16'hF000, 4'b0001);
    checkOutput("single", 16'hF777, 7, 0);

    layerMem[3] = 16'h4FFF;
    applyStimulus(16'hF000, 4'b1001);
    checkOutput("two_layers", 16'hF999, 13, 0);

    layerMem[0] = 16'h0ABC;
    layerMem[1] = 16'h8FFF;
    applyStimulus(16'hF000, 4'b0011);
    checkOutput("skip", 16'hF777, 11, 0);

    fetchLat = 1;
    layerMem[2] = 16'hF5A3;
    applyStimulus(16'h0000, 4'b0100);
    checkOutput("backpressure", 16'hF492, 5, 10);

    fetchLat = 2;
    layerMem[0] = 16'hA123;
    layerMem[1] = 16'h0FFF;
    layerMem[2] = 16'h5C40;
    layerMem[3] = 16'hF9E7;
    applyStimulus(16'h1357, 4'b1111);
    checkOutput("four_layers", 16'hF8D6, 19, 0);

    // Reset while waiting on a slow fetch; its response lands after release.
    fetchLat = 8;
    layerMem[0] = 16'h8FFF;
    applyStimulus(16'hF000, 4'b0001);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checkValue("midreset_busy", 32'(bus.busy), 32'd0);
    checkValue("midreset_fetch_req", 32'(bus.fetch_req), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    sawStale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.fetch_valid === 1'b1) sawStale = 1'b1;
      checkValue("stale_busy", 32'(bus.busy), 32'd0);
      checkValue("stale_out_valid", 32'(bus.out_valid), 32'd0);
      checkValue("stale_blend_prev", 32'(bus.blend_prev), 32'd0);
      checkValue("stale_blend_add", 32'(bus.blend_add), 32'd0);
    end
    checkValue("stale_delivered", 32'(sawStale), 32'd1);

    fetchLat = 3;
    applyStimulus(16'hF000, 4'b0001);
    checkOutput("after_reset", 16'hF777, 7, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
